// File: rtl/fp_arb_pkg.sv
// ============================================================================
// Module      : fp_arb_pkg
// Description : Shared constants and tag type for the two-requester FP adder
//               arbiter and its result-tag pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_arb_pkg;

  // Requester identifiers, also the adder input mux select encoding
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Default datapath width (IEEE-754 single) and adder latency
  localparam int DEF_WIDTH = 32;
  localparam int DEF_LAT   = 3;

  // One in-flight operation: occupied flag plus originating requester
  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

endpackage

`default_nettype wire

// File: rtl/fp_tag_pipe.sv
// ============================================================================
// Module      : fp_tag_pipe
// Description : LAT-deep shift register of {valid, id} tags that tracks each
//               issued adder operation until its result emerges.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_tag_pipe
  import fp_arb_pkg::*;
#(
  parameter int LAT = DEF_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid_i,
  input  logic in_id_i,
  output logic out_valid_o,
  output logic out_id_o
);

  // Stage 0 holds the newest tag, stage LAT-1 the one whose result is due
  tag_t [LAT-1:0] stage_q;
  tag_t           w_tag_in;

  assign w_tag_in = '{valid: in_valid_i, id: in_id_i};

  generate
    if (LAT == 1) begin : g_single
      // Single stage: the tag simply lags the issue by one cycle
      always_ff @(posedge clk or posedge rst) begin
        if (rst) stage_q <= '0;
        else     stage_q <= w_tag_in;
      end
    end else begin : g_multi
      // Shift unconditionally so tags keep moving even when issue is idle
      always_ff @(posedge clk or posedge rst) begin
        if (rst) stage_q <= '0;
        else     stage_q <= {stage_q[LAT-2:0], w_tag_in};
      end
    end
  endgenerate

  assign out_valid_o = stage_q[LAT-1].valid;
  assign out_id_o    = stage_q[LAT-1].id;

endmodule

`default_nettype wire

// File: rtl/fp_add_arbiter.sv
// ============================================================================
// Module      : fp_add_arbiter
// Description : Round-robin arbiter sharing one pipelined FP adder between two
//               requesters; registers the winning operands, drives the adder
//               mux select and steers result-valid back to the issuer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_add_arbiter
  import fp_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LAT   = DEF_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             sel,
  output logic             op_valid,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] res_in,
  output logic [WIDTH-1:0] res_out,
  output logic             res0_valid,
  output logic             res1_valid
);

  logic             ptr_q, ptr_d;
  logic             op_valid_q;
  logic             sel_q;
  logic [WIDTH-1:0] op_a_q, op_b_q;
  logic             w_grant0, w_grant1;
  logic             w_tail_valid, w_tail_id;

  // Grant decision: an uncontested request always wins, a contested one
  // goes to the requester the pointer favours; nothing is granted in reset
  always_comb begin
    w_grant0 = !rst && en && req0_valid && (!req1_valid || (ptr_q == REQ0));
    w_grant1 = !rst && en && req1_valid && (!req0_valid || (ptr_q == REQ1));
    ptr_d    = ptr_q;
    if (w_grant0)      ptr_d = REQ1;
    else if (w_grant1) ptr_d = REQ0;
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  // Issue register: capture the winner's operands; hold them when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= REQ0;
      op_valid_q <= 1'b0;
      sel_q      <= REQ0;
      op_a_q     <= '0;
      op_b_q     <= '0;
    end else begin
      ptr_q      <= ptr_d;
      op_valid_q <= w_grant0 || w_grant1;
      if (w_grant0) begin
        sel_q  <= REQ0;
        op_a_q <= req0_a;
        op_b_q <= req0_b;
      end else if (w_grant1) begin
        sel_q  <= REQ1;
        op_a_q <= req1_a;
        op_b_q <= req1_b;
      end
    end
  end

  assign op_valid = op_valid_q;
  assign sel      = sel_q;
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;

  fp_tag_pipe #(
    .LAT (LAT)
  ) u_tag_pipe (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (op_valid_q),
    .in_id_i     (sel_q),
    .out_valid_o (w_tail_valid),
    .out_id_o    (w_tail_id)
  );

  assign res_out    = res_in;
  assign res0_valid = !rst && w_tail_valid && (w_tail_id == REQ0);
  assign res1_valid = !rst && w_tail_valid && (w_tail_id == REQ1);

endmodule

`default_nettype wire

// File: tb/tb_fp_add_arbiter.sv
// ============================================================================
// Module      : tb_fp_add_arbiter
// Description : Self-checking bench; a LAT=3 and a LAT=1 arbiter share the
//               same stimulus and are compared against a cycle-indexed model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_add_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         v0 = 1'b0, v1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [W-1:0] res_in = '0;

  logic         rdy0_3, rdy1_3, sel_3, opv_3, rv0_3, rv1_3;
  logic [W-1:0] opa_3, opb_3, rout_3;
  logic         rdy0_1, rdy1_1, sel_1, opv_1, rv0_1, rv1_1;
  logic [W-1:0] opa_1, opb_1, rout_1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fp_add_arbiter #(.WIDTH(W), .LAT(3)) u_l3 (
    .clk(clk), .rst(rst), .en(en),
    .req0_valid(v0), .req0_a(a0), .req0_b(b0), .req0_ready(rdy0_3),
    .req1_valid(v1), .req1_a(a1), .req1_b(b1), .req1_ready(rdy1_3),
    .sel(sel_3), .op_valid(opv_3), .op_a(opa_3), .op_b(opb_3),
    .res_in(res_in), .res_out(rout_3), .res0_valid(rv0_3), .res1_valid(rv1_3)
  );

  fp_add_arbiter #(.WIDTH(W), .LAT(1)) u_l1 (
    .clk(clk), .rst(rst), .en(en),
    .req0_valid(v0), .req0_a(a0), .req0_b(b0), .req0_ready(rdy0_1),
    .req1_valid(v1), .req1_a(a1), .req1_b(b1), .req1_ready(rdy1_1),
    .sel(sel_1), .op_valid(opv_1), .op_a(opa_1), .op_b(opb_1),
    .res_in(res_in), .res_out(rout_1), .res0_valid(rv0_1), .res1_valid(rv1_1)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference: who gets the adder this cycle (-1 = nobody)
  function automatic int model_grant(logic e, logic r0, logic r1, logic favour);
    if (!e) return -1;
    if (r0 && r1) return int'(favour);
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  // Model state: favoured requester, issued op, and expected result owner
  // keyed by the absolute cycle number in which the result must appear
  int           cyc = 0;
  logic         m_ptr = 1'b0, m_opv = 1'b0, m_sel = 1'b0;
  logic [W-1:0] m_a = '0, m_b = '0;
  int           exp3[int];
  int           exp1[int];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    int g;
    if (rst) begin
      m_ptr = 1'b0; m_opv = 1'b0; m_sel = 1'b0; m_a = '0; m_b = '0;
      exp3.delete();
      exp1.delete();
    end else begin
      g = model_grant(en, v0, v1, m_ptr);
      m_opv = (g >= 0);
      if (g >= 0) begin
        m_sel = (g == 1);
        m_a   = (g == 1) ? a1 : a0;
        m_b   = (g == 1) ? b1 : b0;
        m_ptr = (g == 0);
        exp3[cyc + 1 + 3] = g + 1;
        exp1[cyc + 1 + 1] = g + 1;
      end
    end
  end

  // Continuous comparison of both builds against the model
  always @(negedge clk) begin
    int g, e3, e1;
    g  = rst ? -1 : model_grant(en, v0, v1, m_ptr);
    e3 = (!rst && exp3.exists(cyc)) ? exp3[cyc] : 0;
    e1 = (!rst && exp1.exists(cyc)) ? exp1[cyc] : 0;
    chk("L3 req0_ready", rdy0_3, g == 0);
    chk("L3 req1_ready", rdy1_3, g == 1);
    chk("L3 op_valid",   opv_3,  m_opv);
    chk("L3 sel",        sel_3,  m_sel);
    chk("L3 op_a",       opa_3,  m_a);
    chk("L3 op_b",       opb_3,  m_b);
    chk("L3 res0_valid", rv0_3,  e3 == 1);
    chk("L3 res1_valid", rv1_3,  e3 == 2);
    chk("L3 res_out",    rout_3, res_in);
    chk("L1 req0_ready", rdy0_1, g == 0);
    chk("L1 req1_ready", rdy1_1, g == 1);
    chk("L1 op_valid",   opv_1,  m_opv);
    chk("L1 sel",        sel_1,  m_sel);
    chk("L1 op_a",       opa_1,  m_a);
    chk("L1 op_b",       opb_1,  m_b);
    chk("L1 res0_valid", rv0_1,  e1 == 1);
    chk("L1 res1_valid", rv1_1,  e1 == 2);
    chk("L1 res_out",    rout_1, res_in);
  end

  typedef struct {
    logic r;
    logic e;
    logic q0;
    logic q1;
    logic er0;
    logic er1;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
    res_in = $urandom();
  endtask

  initial begin
    // {rst, en, v0, v1, expected ready0, expected ready1}, pointer=0 at start
    for (int i = 0; i < 3; i++) begin
      vecs.push_back('{0, 1, 1, 1, 1, 0});
      vecs.push_back('{0, 1, 1, 1, 0, 1});
    end
    for (int i = 0; i < 3; i++) vecs.push_back('{0, 1, 0, 1, 0, 1});
    vecs.push_back('{0, 1, 1, 1, 1, 0});
    vecs.push_back('{0, 1, 1, 1, 0, 1});
    vecs.push_back('{0, 1, 1, 1, 1, 0});
    vecs.push_back('{0, 0, 1, 1, 0, 0});
    vecs.push_back('{0, 0, 1, 1, 0, 0});
    vecs.push_back('{0, 1, 1, 1, 0, 1});
    vecs.push_back('{0, 1, 1, 1, 1, 0});
    vecs.push_back('{0, 1, 1, 1, 0, 1});
    vecs.push_back('{0, 1, 1, 0, 1, 0});
    vecs.push_back('{1, 1, 1, 1, 0, 0});
    vecs.push_back('{0, 1, 1, 1, 1, 0});
    for (int i = 0; i < 5; i++) vecs.push_back('{0, 1, 0, 0, 0, 0});

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // First issue: handshake, registered issue next cycle, result after LAT
    en = 1'b1; v0 = 1'b1; v1 = 1'b0;
    a0 = 32'h3F80_0000; b0 = 32'h4000_0000;
    @(negedge clk);
    chk("first req0_ready", rdy0_3, 1'b1);
    tick();
    v0 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("first op_valid", opv_3, 1'b1);
        chk("first sel",      sel_3, 1'b0);
        chk("first op_a",     opa_3, 32'h3F80_0000);
        chk("first op_b",     opb_3, 32'h4000_0000);
      end
      chk("first L3 res0_valid", rv0_3, k == 4);
      chk("first L1 res0_valid", rv0_1, k == 2);
      tick();
    end

    // Re-enter reset so the table starts from pointer=0
    rst = 1'b1;
    tick();
    rst = 1'b0;

    foreach (vecs[i]) begin
      rst = vecs[i].r; en = vecs[i].e; v0 = vecs[i].q0; v1 = vecs[i].q1;
      a0 = $urandom(); b0 = $urandom(); a1 = $urandom(); b1 = $urandom();
      @(negedge clk);
      chk($sformatf("vec%0d req0_ready", i), rdy0_3, vecs[i].er0);
      chk($sformatf("vec%0d req1_ready", i), rdy1_3, vecs[i].er1);
      tick();
    end
    rst = 1'b0;

    // Randomised traffic, occasionally gating issue
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 7) != 0);
      v0 = $urandom_range(0, 1);
      v1 = $urandom_range(0, 1);
      a0 = $urandom(); b0 = $urandom(); a1 = $urandom(); b1 = $urandom();
      tick();
    end

    en = 1'b0; v0 = 1'b0; v1 = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fp_add_arbiter.md
Name: fp_add_arbiter

Overview:
Shares one fully pipelined floating-point adder between two requesters.
- Arbitrates each cycle with round-robin priority.
- Registers the winning operands and drives the adder's input mux select.
- Tags each issued operation and routes the result-valid strobe back to the originating requester after the adder latency.
- Sits between the two FP operand producers and the single adder/mux datapath.

Parameters:
WIDTH, 32, operand/result width in bits (IEEE-754 single by default)
LAT, 3, adder latency in cycles from op_valid to result on res_in; legal range 1..8

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  issue enable; when 0 no new grants, in-flight ops still complete
req0_valid  input  1  requester 0 has operands
req0_a  input  WIDTH  requester 0 operand A
req0_b  input  WIDTH  requester 0 operand B
req0_ready  output  1  requester 0 handshake accepted this cycle
req1_valid  input  1  requester 1 has operands
req1_a  input  WIDTH  requester 1 operand A
req1_b  input  WIDTH  requester 1 operand B
req1_ready  output  1  requester 1 handshake accepted this cycle
sel  output  1  adder input mux select (0 = requester 0 path, 1 = requester 1 path)
op_valid  output  1  adder input valid
op_a  output  WIDTH  registered operand A to adder
op_b  output  WIDTH  registered operand B to adder
res_in  input  WIDTH  adder result
res_out  output  WIDTH  result passthrough, equal to res_in (combinational)
res0_valid  output  1  res_out belongs to requester 0 this cycle
res1_valid  output  1  res_out belongs to requester 1 this cycle

Behaviour:
- Reset (async, rst=1): op_valid=0, sel=0, op_a=op_b=0, tag pipeline cleared, priority pointer=0 (requester 0 favoured). While rst=1: req*_ready=0 and res*_valid=0.
- Ready is combinational from valid, en and the pointer. At most one ready is high per cycle. The handshake is valid&ready, and both requesters have ready=1 when selected.
- Grant rules, with en=1:
  - only req0_valid → grant 0.
  - only req1_valid → grant 1.
  - both valid → grant the requester indicated by the pointer.
  - no request or en=0 → no grant.
- Pointer update: after any grant, the pointer moves to the non-granted requester. With no grant it holds.
- Issue timing: handshake in cycle T → op_valid=1, sel=granted id, op_a/op_b=granted operands in cycle T+1.
  - With no grant, op_valid=0 in T+1 and op_a/op_b/sel hold their previous values.
- Throughput: one issue per cycle, back-to-back, no bubbles.
- Tag pipeline: a LAT-deep shift register of {valid, id}, loaded from {op_valid, sel}.
  - For op_valid in cycle T+1, the result is on res_in in cycle T+1+LAT.
  - In that cycle exactly one of res0_valid/res1_valid is 1, selected by id.
  - There is no result backpressure; requesters must sink results.
- en deassertion mid-stream: the pipeline keeps shifting, so outstanding results still return with correct tags.
- Reset mid-operation: all in-flight tags are dropped and no res*_valid fires for them. After release, the first grant follows pointer=0.
- LAT=1: the tag register is a single stage and behaviour is otherwise identical.

Decomposition:
- Shared package fp_arb_pkg: requester id constants REQ0=0, REQ1=1, default WIDTH/LAT, and the packed tag struct {valid, id}.
- One natural sub-module: fp_tag_pipe, the LAT-deep tag shift register with async reset. The arbiter and issue registers stay in the top.

Test Plan:
- Reset then req0_valid=1 only, a=0x3F800000, b=0x40000000 → req0_ready=1 cycle 0; op_valid=1, sel=0, op_a=0x3F800000 cycle 1; res0_valid=1 cycle 1+LAT.
- Both requesters valid continuously for 6 cycles after reset → grants 0,1,0,1,0,1; sel sequence identical one cycle later; res0/res1_valid alternate LAT cycles after that.
- Only req1_valid for 3 cycles, then both valid → first contested grant goes to requester 0 (pointer after req1 grants = 0).
- en=0 for 2 cycles during a continuous both-valid stream → ready=0 and no op_valid for those slots; results already in flight still return with correct res*_valid.
- Assert rst for 1 cycle while 3 ops are in flight → no res*_valid for them afterward; op_valid=0 immediately; next contested grant goes to requester 0.
- LAT=1 build, issue alternating requesters back-to-back → res*_valid toggles every cycle, aligned one cycle after op_valid.
